// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the highway/farm-road
// intersection controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      HG = 2'd0,
      HY = 2'd1,
      FG = 2'd2,
      FY = 2'd3
   } state_t;

   localparam logic [1:0] LIGHT_G = 2'b10;
   localparam logic [1:0] LIGHT_Y = 2'b01;
   localparam logic [1:0] LIGHT_R = 2'b00;

endpackage

// File: rtl/interval_timer.sv
// Interval timer: restarts on request, saturates at TL-1 and
// flags short (TS) and long (TL) elapsed intervals.
module interval_timer #(
   parameter int TS = 5,
   parameter int TL = 15
) (
   input  logic clk1,
   input  logic rst_n,
   input  logic restart,
   output logic ts,
   output logic tl
);

   localparam int W = $clog2(TL);
   localparam logic [W-1:0] TS_M = W'(TS - 1);
   localparam logic [W-1:0] TL_M = W'(TL - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= '0;
      end else if (cnt != TL_M) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign ts = (cnt >= TS_M);
   assign tl = (cnt >= TL_M);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Moore controller for a highway/farm-road crossing with a
// farm car sensor and a pedestrian walk request.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int TS = 5,
   parameter int TL = 15
) (
   input  logic       clk1,
   input  logic       rst_n,
   input  logic       car,
   input  logic       ped_req,
   output logic [1:0] hl,
   output logic [1:0] fl,
   output logic       walk,
   output logic [1:0] state
);

   state_t cur;
   state_t nxt;

   logic car_m, car_s;
   logic ped_m, ped_s, ped_q;
   logic ped_pending, walk_active;
   logic ts, tl, restart;
   logic ped_rise, fg_entry, fg_exit;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         car_m <= 1'b0;
         car_s <= 1'b0;
         ped_m <= 1'b0;
         ped_s <= 1'b0;
         ped_q <= 1'b0;
      end else begin
         car_m <= car;
         car_s <= car_m;
         ped_m <= ped_req;
         ped_s <= ped_m;
         ped_q <= ped_s;
      end
   end

   assign ped_rise = ped_s & ~ped_q;
   assign restart  = (nxt != cur);
   assign fg_entry = (cur == HY) && (nxt == FG);
   assign fg_exit  = (cur == FG) && (nxt != FG);

   // A request edge coinciding with FG entry is served now.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         ped_pending <= 1'b0;
         walk_active <= 1'b0;
      end else if (fg_entry) begin
         walk_active <= ped_pending | ped_rise;
         ped_pending <= 1'b0;
      end else begin
         if (ped_rise) ped_pending <= 1'b1;
         if (fg_exit)  walk_active <= 1'b0;
      end
   end

   interval_timer #(
      .TS(TS),
      .TL(TL)
   ) u_timer (
      .clk1   (clk1),
      .rst_n  (rst_n),
      .restart(restart),
      .ts     (ts),
      .tl     (tl)
   );

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) cur <= HG;
      else        cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      unique case (cur)
         HG: if (tl && (car_s || ped_pending)) nxt = HY;
         HY: if (ts) nxt = FG;
         FG: begin
            if (walk_active) begin
               if (tl) nxt = FY;
            end else if (tl || !car_s) begin
               nxt = FY;
            end
         end
         FY: if (ts) nxt = HG;
         default: nxt = HG;
      endcase
   end

   always_comb begin
      hl = LIGHT_R;
      fl = LIGHT_R;
      unique case (cur)
         HG: hl = LIGHT_G;
         HY: hl = LIGHT_Y;
         FG: fl = LIGHT_G;
         FY: fl = LIGHT_Y;
         default: hl = LIGHT_G;
      endcase
   end

   assign walk  = (cur == FG) && walk_active;
   assign state = cur;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus random
// car/pedestrian traffic against a behavioural model.
module tb_traffic_light_ctrl;

   localparam int TS = 5;
   localparam int TL = 15;

   logic       clk1 = 1'b0;
   logic       rst_n;
   logic       car;
   logic       ped_req;
   logic [1:0] hl;
   logic [1:0] fl;
   logic       walk;
   logic [1:0] state;

   always #5 clk1 = ~clk1;

   traffic_light_ctrl #(
      .TS(TS),
      .TL(TL)
   ) dut (
      .clk1   (clk1),
      .rst_n  (rst_n),
      .car    (car),
      .ped_req(ped_req),
      .hl     (hl),
      .fl     (fl),
      .walk   (walk),
      .state  (state)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // model: phase 0..3 = HG,HY,FG,FY; t = ticks spent in phase
   int ph, t;
   bit cm, cs, pm, ps, pq, pend, wa;

   int last_st = -1;
   int run_len = 0;
   bit run_ok = 0;
   bit run_walk = 0;

   function automatic void model_reset();
      ph = 0; t = 0;
      cm = 0; cs = 0; pm = 0; ps = 0; pq = 0;
      pend = 0; wa = 0;
   endfunction

   task automatic model_step();
      int nx;
      bit rise;
      nx = ph;
      rise = ps && !pq;
      case (ph)
         0: if (t >= TL - 1 && (cs || pend)) nx = 1;
         1: if (t >= TS - 1) nx = 2;
         2: if (t >= TL - 1 || (!wa && !cs)) nx = 3;
         default: if (t >= TS - 1) nx = 0;
      endcase
      if (ph == 1 && nx == 2) begin
         wa = pend || rise;
         pend = 0;
      end else if (rise) begin
         pend = 1;
      end
      if (ph == 2 && nx != 2) wa = 0;
      t = (nx != ph) ? 0 : t + 1;
      ph = nx;
      pq = ps; ps = pm; pm = ped_req;
      cs = cm; cm = car;
   endtask

   task automatic chk(input string n, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", n, got, exp);
      end
   endtask

   task automatic check_run(input int st, input int len, input bit w);
      bit ok;
      case (st)
         0: ok = (len >= TL);
         1, 3: ok = (len == TS);
         default: ok = (len >= 1) && (len <= TL) && (!w || len == TL);
      endcase
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL duration st%0d: got %0d cycles (walk=%0d)",
                  st, len, w);
      end
   endtask

   task automatic compare();
      logic [1:0] eh, ef, es;
      logic ew;
      eh = (ph == 0) ? 2'b10 : (ph == 1) ? 2'b01 : 2'b00;
      ef = (ph == 2) ? 2'b10 : (ph == 3) ? 2'b01 : 2'b00;
      ew = (ph == 2) && wa;
      es = ph[1:0];
      checks++;
      if (hl !== eh || fl !== ef || walk !== ew || state !== es) begin
         errors++;
         $display("FAIL outputs cyc%0d: got hl=%b fl=%b walk=%b st=%0d, exp hl=%b fl=%b walk=%b st=%0d",
                  cyc, hl, fl, walk, state, eh, ef, ew, es);
      end
      if (int'(state) == last_st) begin
         run_len++;
         run_walk |= walk;
      end else begin
         if (run_ok) check_run(last_st, run_len, run_walk);
         run_ok = 1;
         last_st = int'(state);
         run_len = 1;
         run_walk = walk;
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      if (rst_n) model_step();
      @(negedge clk1);
      cyc++;
      compare();
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 run_ok = 0;
      model_reset();
      compare();
      chk("rst_hl", int'(hl), 2);
      chk("rst_fl", int'(fl), 0);
      chk("rst_walk", int'(walk), 0);
      chk("rst_state", int'(state), 0);
      @(negedge clk1);
      tick();
      tick();
      rst_n = 1'b1;
      cyc = 0;
   endtask

   int wcnt;
   int hold;

   initial begin
      rst_n = 1'b0;
      car = 1'b0;
      ped_req = 1'b0;
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      cyc = 0;

      // idle: no requests, HG forever
      run_to(100);
      chk("idle_state", int'(state), 0);
      chk("idle_hl", int'(hl), 2);

      // car present from release; reset mid-FY
      car = 1'b1;
      do_reset();
      run_to(14);  chk("car_hg14", int'(state), 0);
      run_to(15);  chk("car_hy15", int'(state), 1);
      run_to(20);  chk("car_fg20", int'(state), 2);
      run_to(34);  chk("car_fg34", int'(state), 2);
      run_to(35);  chk("car_fy35", int'(state), 3);
      run_to(37);
      do_reset();
      run_to(14);  chk("rst_hg14", int'(state), 0);
      run_to(15);  chk("rst_hy15", int'(state), 1);

      // car leaves 3 cycles into FG
      do_reset();
      run_to(20);  chk("drop_fg20", int'(state), 2);
      run_to(23);
      car = 1'b0;
      run_to(25);  chk("drop_fg25", int'(state), 2);
      run_to(26);  chk("drop_fy26", int'(state), 3);
      run_to(30);  chk("drop_fy30", int'(state), 3);
      run_to(31);  chk("drop_hg31", int'(state), 0);

      // pedestrian pulses at cycle 4 and during the walk FG
      do_reset();
      wcnt = 0;
      while (cyc < 40) begin
         ped_req = (cyc == 3 || cyc == 24);
         tick();
         wcnt += int'(walk);
         if (cyc == 15) chk("ped_hy15", int'(state), 1);
         if (cyc == 20) chk("ped_walk20", int'(walk), 1);
      end
      ped_req = 1'b0;
      chk("ped_walk_len", wcnt, 15);
      run_to(55);  chk("ped2_hy55", int'(state), 1);
      run_to(60);  chk("ped2_walk60", int'(walk), 1);
      run_to(120); chk("ped_no_dup", int'(state), 0);

      // reset during a walk FG
      do_reset();
      while (cyc < 25) begin
         ped_req = (cyc == 3);
         tick();
      end
      chk("walk_before_rst", int'(walk), 1);
      do_reset();
      run_to(40);  chk("walk_rst_hg", int'(state), 0);

      // random traffic
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            car = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 40);
         end else begin
            hold--;
         end
         if (ped_req) ped_req = 1'b0;
         else ped_req = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 1499) == 0) do_reset();
         else tick();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
